// File: rtl/movegen_scan.sv
// movegen_scan: steps the move-generator square array through each side-to-move
// piece, snapshots the returned target bitmap and serialises the resulting
// (from, to) pairs through a show-ahead valid/ready FIFO.
// Optional feature macro: MOVEGEN_SCAN_ABORT_EN (honours i_abort when defined).
module movegen_scan #(
  parameter  int unsigned FILES = 8,
  parameter  int unsigned RANKS = 8,
  parameter  int unsigned DEPTH = 8,
  parameter  int unsigned CNT_W = 8,
  localparam int unsigned NSQ   = FILES * RANKS,
  localparam int unsigned SQ_W  = (NSQ > 1) ? $clog2(NSQ) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [NSQ-1:0]   i_src,
  output logic [NSQ-1:0]   o_emit,
  input  logic [NSQ-1:0]   i_target,
  input  logic             i_abort,
  output logic             busy,
  output logic             done,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SQ_W-1:0]  out_from,
  output logic [SQ_W-1:0]  out_to,
  output logic [CNT_W-1:0] out_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SELECT,
    S_EMIT,
    S_DRAIN,
    S_FLUSH,
    S_DONE
  } state_t;

  typedef struct packed {
    logic [SQ_W-1:0] from;
    logic [SQ_W-1:0] to;
  } move_t;

  state_t          state;
  logic [NSQ-1:0]  src_mask;
  logic [NSQ-1:0]  tgt_mask;
  logic [SQ_W-1:0] cur_from;

  move_t           mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;

  logic            abort_c;
  logic            fifo_full_c;
  logic            fifo_empty_c;
  logic            push_c;
  logic            pop_c;
  logic [PW-1:0]   occ_c;
  logic [PW-1:0]   wr_ptr_nx_c;
  logic [PW-1:0]   rd_ptr_nx_c;
  move_t           push_data_c;
  move_t           head_nx_c;

  // Index of the lowest set bit; zero for an empty mask.
  function automatic logic [SQ_W-1:0] lowest_idx(input logic [NSQ-1:0] m);
    logic [SQ_W-1:0] idx;
    idx = '0;
    for (int i = int'(NSQ) - 1; i >= 0; i--) begin
      if (m[i]) idx = SQ_W'(i);
    end
    return idx;
  endfunction

`ifdef MOVEGEN_SCAN_ABORT_EN
  assign abort_c = i_abort && (state != S_IDLE);
`else
  logic unused_abort;
  assign unused_abort = i_abort;
  assign abort_c      = 1'b0;
`endif

  // FIFO status from the registered pointers; push is refused at full occupancy.
  assign occ_c        = wr_ptr - rd_ptr;
  assign fifo_full_c  = (occ_c == PW'(DEPTH));
  assign fifo_empty_c = (wr_ptr == rd_ptr);
  assign push_c       = (state == S_DRAIN) && (tgt_mask != '0) && !fifo_full_c && !abort_c;
  assign pop_c        = out_valid && out_ready;
  assign push_data_c  = {cur_from, lowest_idx(tgt_mask)};

  // Next pointers and next head entry, forwarding a push into an otherwise empty FIFO.
  always_comb begin
    wr_ptr_nx_c = wr_ptr + PW'(push_c);
    rd_ptr_nx_c = rd_ptr + PW'(pop_c);
    head_nx_c   = mem[rd_ptr_nx_c[AW-1:0]];
    if (push_c && (wr_ptr[AW-1:0] == rd_ptr_nx_c[AW-1:0])) begin
      head_nx_c = push_data_c;
    end
  end

  // FIFO storage write.
  always_ff @(posedge clk) begin
    if (push_c) begin
      mem[wr_ptr[AW-1:0]] <= push_data_c;
    end
  end

  // FIFO pointers and registered head outputs; abort empties the queue.
  always_ff @(posedge clk) begin
    if (!rst_n || abort_c) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      out_valid <= 1'b0;
      out_from  <= '0;
      out_to    <= '0;
    end else begin
      wr_ptr    <= wr_ptr_nx_c;
      rd_ptr    <= rd_ptr_nx_c;
      out_valid <= (wr_ptr_nx_c != rd_ptr_nx_c);
      if (wr_ptr_nx_c != rd_ptr_nx_c) begin
        out_from <= head_nx_c.from;
        out_to   <= head_nx_c.to;
      end
    end
  end

  // Scan sequencer: source select, array strobe, target expansion, completion.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      src_mask  <= '0;
      tgt_mask  <= '0;
      cur_from  <= '0;
      o_emit    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      out_count <= '0;
    end else if (abort_c) begin
      state    <= S_IDLE;
      src_mask <= '0;
      tgt_mask <= '0;
      o_emit   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done   <= 1'b0;
      o_emit <= '0;
      case (state)
        S_IDLE: begin
          if (start) begin
            src_mask  <= i_src;
            out_count <= '0;
            busy      <= 1'b1;
            state     <= S_SELECT;
          end
        end
        S_SELECT: begin
          if (src_mask == '0) begin
            state <= S_FLUSH;
          end else begin
            cur_from <= lowest_idx(src_mask);
            o_emit   <= src_mask & (~src_mask + NSQ'(1));
            src_mask <= src_mask & (src_mask - NSQ'(1));
            state    <= S_EMIT;
          end
        end
        S_EMIT: begin
          tgt_mask <= i_target;
          state    <= S_DRAIN;
        end
        S_DRAIN: begin
          if (tgt_mask == '0) begin
            state <= S_SELECT;
          end else if (push_c) begin
            tgt_mask <= tgt_mask & (tgt_mask - NSQ'(1));
            if (out_count != '1) out_count <= out_count + CNT_W'(1);
          end
        end
        S_FLUSH: begin
          if (fifo_empty_c) begin
            done  <= 1'b1;
            state <= S_DONE;
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_movegen_scan.sv
// tb_movegen_scan: 8x8 board, 4-entry FIFO, 5-bit move counter. A queue model
// predicts the source strobe order and the (from, to) stream; directed scans
// pin the model with hand-computed values, then randomized scans follow.
`timescale 1ns/1ps
module tb_movegen_scan;

  localparam int unsigned FILES   = 8;
  localparam int unsigned RANKS   = 8;
  localparam int unsigned NSQ     = 64;
  localparam int unsigned SQ_W    = 6;
  localparam int unsigned DEPTH   = 4;
  localparam int unsigned CNT_W   = 5;
  localparam int          CNT_MAX = 31;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [NSQ-1:0]   i_src;
  logic [NSQ-1:0]   o_emit;
  logic [NSQ-1:0]   i_target;
  logic             i_abort;
  logic             busy;
  logic             done;
  logic             out_valid;
  logic             out_ready;
  logic [SQ_W-1:0]  out_from;
  logic [SQ_W-1:0]  out_to;
  logic [CNT_W-1:0] out_count;

  logic [NSQ-1:0]   tgt_tab [NSQ];
  logic [NSQ-1:0]   junk;
  int               exp_q[$];
  int               src_q[$];
  int               got_q[$];
  int               n_checks = 0;
  int               n_pass   = 0;
  int               done_cnt = 0;
  int               scan_d0  = 0;
  int               ready_mode = 0;
  int               cmp_pair;
  int               cmp_exp;

  movegen_scan #(
    .FILES(FILES), .RANKS(RANKS), .DEPTH(DEPTH), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .i_src(i_src), .o_emit(o_emit),
    .i_target(i_target), .i_abort(i_abort), .busy(busy), .done(done),
    .out_valid(out_valid), .out_ready(out_ready), .out_from(out_from),
    .out_to(out_to), .out_count(out_count)
  );

  always #5 clk = ~clk;

  // Combinational square-array stand-in: the strobed square returns its targets.
  always_comb begin
    i_target = junk;
    for (int i = 0; i < int'(NSQ); i++) begin
      if (o_emit[i]) i_target = tgt_tab[i];
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
  endtask

  // Model: sources in ascending order, and for each its targets in ascending order.
  task automatic build_model(input logic [NSQ-1:0] src, output int total);
    total = 0;
    for (int f = 0; f < int'(NSQ); f++) begin
      if (src[f]) begin
        src_q.push_back(f);
        for (int t = 0; t < int'(NSQ); t++) begin
          if (tgt_tab[f][t]) begin
            exp_q.push_back(f * 64 + t);
            total++;
          end
        end
      end
    end
  endtask

  // Consumer ready and array junk, driven between edges.
  initial begin
    out_ready = 1'b1;
    junk      = '0;
    forever begin
      @(posedge clk);
      #2;
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'b0;
        default: out_ready = ($urandom_range(0, 1) == 1);
      endcase
      junk = {$urandom, $urandom};
    end
  end

  // Per-cycle compare of strobes and handshakes against the model queues.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (o_emit != '0) begin
          check("emit_onehot", 64'($countones(o_emit)), 64'd1);
          if (src_q.size() == 0) check("emit_unexpected", o_emit, 64'd0);
          else check("emit_src", o_emit, 64'd1 << src_q.pop_front());
        end
        if (done) done_cnt++;
        if (out_valid && out_ready) begin
          cmp_pair = int'(out_from) * 64 + int'(out_to);
          got_q.push_back(cmp_pair);
          if (exp_q.size() == 0) begin
            check("pop_unexpected", 64'(cmp_pair), 64'hFFFF);
          end else begin
            cmp_exp = exp_q.pop_front();
            check("pop_pair", 64'(cmp_pair), 64'(cmp_exp));
          end
        end
      end
    end
  end

  task automatic apply_reset();
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_q.delete();
    src_q.delete();
  endtask

  // Start a scan; returns in the first EMIT cycle (two cycles after start).
  task automatic start_scan(input logic [NSQ-1:0] src, output int total);
    build_model(src, total);
    scan_d0 = done_cnt;
    i_src = src;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    i_src = {$urandom, $urandom};
    check("busy_after_start", 64'(busy), 64'd1);
    @(posedge clk); #1;
    check("first_emit", o_emit, src & (~src + 64'd1));
  endtask

  task automatic finish_scan(input int total);
    int cyc;
    cyc = 0;
    while (!done && cyc < 5000) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("done_pulse", 64'(done), 64'd1);
    check("out_count", 64'(out_count), 64'((total > CNT_MAX) ? CNT_MAX : total));
    check("moves_left", 64'(exp_q.size()), 64'd0);
    check("sources_left", 64'(src_q.size()), 64'd0);
    @(posedge clk); #1;
    check("idle_after_done", 64'({busy, done}), 64'd0);
    check("done_count", 64'(done_cnt - scan_d0), 64'd1);
    if (busy || exp_q.size() != 0 || src_q.size() != 0) apply_reset();
  endtask

  initial begin
    int total;
    int p0;
    int cyc;
    rst_n   = 1'b0;
    start   = 1'b0;
    i_abort = 1'b0;
    i_src   = '0;
    for (int i = 0; i < int'(NSQ); i++) tgt_tab[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_emit", o_emit, 64'd0);
    check("rst_head", 64'({out_from, out_to}), 64'd0);
    check("rst_count", 64'(out_count), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Empty scan: done three cycles after start; a start coincident with done is dropped.
    build_model('0, total);
    scan_d0 = done_cnt;
    i_src = '0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("empty_select_done", 64'(done), 64'd0);
    @(posedge clk); #1;
    check("empty_flush_done", 64'(done), 64'd0);
    check("empty_flush_busy", 64'(busy), 64'd1);
    @(posedge clk); #1;
    check("empty_done", 64'(done), 64'd1);
    start = 1'b1;
    i_src = 64'h00FF;
    @(posedge clk); #1;
    start = 1'b0;
    check("start_on_done_ignored", 64'({busy, done}), 64'd0);
    check("empty_count", 64'(out_count), 64'd0);
    check("empty_done_count", 64'(done_cnt - scan_d0), 64'd1);

    // Opening position for white: 16 pawn pushes plus 4 knight moves.
    for (int f = 8; f < 16; f++) tgt_tab[f] = (64'd1 << (f + 8)) | (64'd1 << (f + 16));
    tgt_tab[1] = (64'd1 << 16) | (64'd1 << 18);
    tgt_tab[6] = (64'd1 << 21) | (64'd1 << 23);
    ready_mode = 0;
    p0 = got_q.size();
    start_scan(64'hFFFF, total);
    check("start_model_total", 64'(total), 64'd20);
    finish_scan(total);
    check("start_pairs", 64'(got_q.size() - p0), 64'd20);
    check("start_first_pair", 64'(got_q[p0]), 64'(1 * 64 + 16));
    check("start_last_pair", 64'(got_q[got_q.size() - 1]), 64'(15 * 64 + 31));

    // Backpressure: one source with 8 targets fills the 4-entry FIFO and stalls.
    tgt_tab[5] = 64'h8000_0000_0000_00FE;
    ready_mode = 1;
    @(posedge clk); #1;
    p0 = got_q.size();
    start_scan(64'h20, total);
    for (int c = 0; c < 20; c++) begin
      if (c == 5) begin
        start = 1'b1;
        i_src = '1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    check("stall_count", 64'(out_count), 64'd4);
    check("stall_valid", 64'(out_valid), 64'd1);
    check("stall_busy", 64'({busy, done}), 64'b10);
    check("stall_no_pops", 64'(got_q.size() - p0), 64'd0);
    ready_mode = 0;
    finish_scan(total);
    check("stall_pairs", 64'(got_q.size() - p0), 64'd8);

    // Counter saturation: 36 moves against a 5-bit counter.
    tgt_tab[2]  = 64'h0000_0000_00FF_F000;
    tgt_tab[40] = 64'hFFF0_0000_0000_0000;
    tgt_tab[50] = 64'h0000_0FFF_0000_0000;
    ready_mode = 2;
    p0 = got_q.size();
    start_scan((64'd1 << 2) | (64'd1 << 40) | (64'd1 << 50), total);
    check("sat_model_total", 64'(total), 64'd36);
    finish_scan(total);
    check("sat_count", 64'(out_count), 64'd31);
    check("sat_pairs", 64'(got_q.size() - p0), 64'd36);

    // Reset in DRAIN with three entries queued, then a clean rerun.
    tgt_tab[20] = 64'h8000_0100_4000_0208;
    ready_mode = 1;
    @(posedge clk); #1;
    start_scan(64'd1 << 20, total);
    repeat (4) @(posedge clk);
    #1;
    check("pre_reset_count", 64'(out_count), 64'd3);
    check("pre_reset_valid", 64'(out_valid), 64'd1);
    apply_reset();
    check("post_reset_valid", 64'(out_valid), 64'd0);
    check("post_reset_busy", 64'(busy), 64'd0);
    check("post_reset_count", 64'(out_count), 64'd0);
    ready_mode = 0;
    @(posedge clk); #1;
    start_scan(64'd1 << 20, total);
    finish_scan(total);

    // Abort strobed during the second source's EMIT cycle.
    tgt_tab[3] = 64'h7000;
    tgt_tab[7] = 64'h3_0000_0000;
    ready_mode = 0;
    start_scan(64'h88, total);
    cyc = 0;
    while (!o_emit[7] && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("abort_emit_seen", 64'(o_emit[7]), 64'd1);
    i_abort = 1'b1;
    @(posedge clk); #1;
    i_abort = 1'b0;
`ifdef MOVEGEN_SCAN_ABORT_EN
    check("abort_idle", 64'({busy, out_valid}), 64'd0);
    check("abort_emit_low", o_emit, 64'd0);
    check("abort_count_held", 64'(out_count), 64'd3);
    exp_q.delete();
    src_q.delete();
    repeat (5) @(posedge clk);
    #1;
    check("abort_no_done", 64'(done_cnt - scan_d0), 64'd0);
`else
    finish_scan(total);
`endif

    // Randomized scans under random backpressure.
    for (int s = 0; s < 10; s++) begin
      for (int i = 0; i < int'(NSQ); i++) begin
        tgt_tab[i] = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
      end
      ready_mode = (s % 3 == 0) ? 0 : 2;
      @(posedge clk); #1;
      start_scan({$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom}, total);
      finish_scan(total);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
